// File: rtl/simon_datapath.sv
// Simon game datapath: pattern memory, sequence length (count) and playback
// position (index) registers, plus the status flags and LED mux for the FSM.
module simon_datapath #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level,
    input  logic [3:0] pattern,
    input  logic       set_level,
    input  logic       w_en,
    input  logic       cnt_count,
    input  logic       clr_count,
    input  logic       cnt_index,
    input  logic       clr_index,
    input  logic       read_Memory,
    output logic       index_lt_count,
    output logic       input_eq_pattern,
    output logic       is_legal,
    output logic [3:0] pattern_leds
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    logic              level_q, level_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [3:0]        mem_q [DEPTH];
    logic [3:0]        mem_rd_s;

    // Hard mode accepts exactly one pressed switch.
    function automatic logic is_one_hot(input logic [3:0] p);
        return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
    endfunction

    // Next-state for level latch and the two saturating counters (clear wins over increment).
    always_comb begin
        level_d = level_q;
        count_d = count_q;
        index_d = index_q;
        if (set_level) begin
            level_d = level;
        end else begin
            level_d = level_q;
        end
        if (clr_count) begin
            count_d = '0;
        end else if (cnt_count && (count_q != LAST_ADDR)) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
        if (clr_index) begin
            index_d = '0;
        end else if (cnt_index && (index_q != LAST_ADDR)) begin
            index_d = index_q + ONE;
        end else begin
            index_d = index_q;
        end
    end

    // State registers; reset clears the counters but the level still loads on set_level.
    always_ff @(posedge clk) begin
        level_q <= level_d;
        if (rst) begin
            count_q <= '0;
            index_q <= '0;
        end else begin
            count_q <= count_d;
            index_q <= index_d;
        end
    end

    // Pattern store, addressed by the pre-edge count; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_q[count_q] <= pattern;
        end
    end

    // Asynchronous read so flags are valid in the same cycle the FSM samples them.
    assign mem_rd_s         = mem_q[index_q];
    assign index_lt_count   = (index_q < count_q);
    assign input_eq_pattern = (pattern == mem_rd_s);
    assign is_legal         = level_q ? is_one_hot(pattern) : 1'b1;
    assign pattern_leds     = read_Memory ? mem_rd_s : pattern;

endmodule

// File: tb/tb_simon_datapath.sv
// Self-checking bench for simon_datapath: integer-level reference model checked
// every cycle, plus directed literal expectations from hand calculation.
module tb_simon_datapath;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int MAXC   = DEPTH - 1;

    logic       clk = 1'b0;
    logic       rst, level, set_level, w_en, cnt_count, clr_count;
    logic       cnt_index, clr_index, read_Memory;
    logic [3:0] pattern;
    logic       index_lt_count, input_eq_pattern, is_legal;
    logic [3:0] pattern_leds;

    int errors = 0;
    int checks = 0;

    simon_datapath #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .level           (level),
        .pattern         (pattern),
        .set_level       (set_level),
        .w_en            (w_en),
        .cnt_count       (cnt_count),
        .clr_count       (clr_count),
        .cnt_index       (cnt_index),
        .clr_index       (clr_index),
        .read_Memory     (read_Memory),
        .index_lt_count  (index_lt_count),
        .input_eq_pattern(input_eq_pattern),
        .is_legal        (is_legal),
        .pattern_leds    (pattern_leds)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, a memory array and a written-flag per entry.
    int         m_count = 0;
    int         m_index = 0;
    bit         m_level = 1'b0;
    bit         m_ok    = 1'b0;
    logic [3:0] m_mem   [DEPTH];
    bit         m_valid [DEPTH];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (w_en) begin
            m_mem[m_count]   = pattern;
            m_valid[m_count] = 1'b1;
        end
        if (set_level) m_level = level;
        if (rst) begin
            m_count = 0;
            m_index = 0;
            m_ok    = 1'b1;
        end else begin
            if (clr_count)      m_count = 0;
            else if (cnt_count) m_count = (m_count < MAXC) ? m_count + 1 : MAXC;
            if (clr_index)      m_index = 0;
            else if (cnt_index) m_index = (m_index < MAXC) ? m_index + 1 : MAXC;
        end
    end

    // Compare every cycle, mid-period, once the model has seen a reset.
    always @(negedge clk) begin
        if (m_ok) begin
            check("model_lt", int'(index_lt_count), int'(m_index < m_count));
            check("model_legal", int'(is_legal),
                  int'(!m_level || ($countones(pattern) == 1)));
            if (m_valid[m_index]) begin
                check("model_eq", int'(input_eq_pattern), int'(pattern == m_mem[m_index]));
                check("model_leds", int'(pattern_leds),
                      int'(read_Memory ? m_mem[m_index] : pattern));
            end else if (!read_Memory) begin
                check("model_leds_live", int'(pattern_leds), int'(pattern));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic strobes_off();
        rst = 1'b0; set_level = 1'b0; w_en = 1'b0;
        cnt_count = 1'b0; clr_count = 1'b0; cnt_index = 1'b0; clr_index = 1'b0;
    endtask

    logic [3:0] pats  [5];
    logic       hard_exp [5];

    initial begin
        pats[0] = 4'b0001; pats[1] = 4'b0100; pats[2] = 4'b0000;
        pats[3] = 4'b0110; pats[4] = 4'b1111;
        hard_exp[0] = 1'b1; hard_exp[1] = 1'b1; hard_exp[2] = 1'b0;
        hard_exp[3] = 1'b0; hard_exp[4] = 1'b0;

        strobes_off();
        read_Memory = 1'b0;
        pattern     = 4'd0;
        rst = 1'b1; set_level = 1'b1; level = 1'b1;
        tick();
        strobes_off();
        #1;
        check("reset_lt", int'(index_lt_count), 0);

        // Hard-mode legality, then level change without set_level is ignored.
        for (int i = 0; i < 5; i++) begin
            pattern = pats[i];
            #1;
            check("hard_legal", int'(is_legal), int'(hard_exp[i]));
        end
        level = 1'b0;
        pattern = 4'b0000;
        #1;
        check("level_not_latched", int'(is_legal), 0);
        rst = 1'b1; set_level = 1'b1;
        tick();
        strobes_off();
        for (int i = 0; i < 5; i++) begin
            pattern = pats[i];
            #1;
            check("easy_legal", int'(is_legal), 1);
        end

        // Write and playback.
        pattern = 4'b0010; w_en = 1'b1;
        tick();
        strobes_off();
        #1;
        check("after_write_lt", int'(index_lt_count), 0);
        read_Memory = 1'b1;
        #1;
        check("playback_leds", int'(pattern_leds), 2);
        cnt_count = 1'b1;
        tick();
        strobes_off();
        #1;
        check("count1_lt", int'(index_lt_count), 1);
        cnt_index = 1'b1;
        tick();
        strobes_off();
        #1;
        check("index1_lt", int'(index_lt_count), 0);

        // Compare against mem[0].
        clr_index = 1'b1;
        tick();
        strobes_off();
        pattern = 4'b0010;
        #1;
        check("eq_match", int'(input_eq_pattern), 1);
        pattern = 4'b0011;
        #1;
        check("eq_miss", int'(input_eq_pattern), 0);
        read_Memory = 1'b0; pattern = 4'b1001;
        #1;
        check("live_leds", int'(pattern_leds), 9);

        // Read-during-write returns old data; count=1, index moves to 1.
        cnt_index = 1'b1; w_en = 1'b1; pattern = 4'b0100;
        tick();
        strobes_off();
        read_Memory = 1'b1; w_en = 1'b1; pattern = 4'b1000;
        #1;
        check("rdw_old", int'(pattern_leds), 4);
        tick();
        strobes_off();
        #1;
        check("rdw_new", int'(pattern_leds), 8);

        // Priorities: index to 5, clear+count -> 0.
        for (int i = 0; i < 4; i++) begin
            cnt_index = 1'b1;
            tick();
        end
        clr_index = 1'b1; cnt_index = 1'b1;
        tick();
        strobes_off();
        #1;
        check("clr_idx_prio_leds", int'(pattern_leds), 2);
        for (int i = 0; i < 2; i++) begin
            cnt_count = 1'b1;
            tick();
        end
        clr_count = 1'b1; cnt_count = 1'b1;
        tick();
        strobes_off();
        #1;
        check("clr_cnt_prio_lt", int'(index_lt_count), 0);
        cnt_count = 1'b1;
        tick();
        tick();
        w_en = 1'b1; cnt_count = 1'b1; pattern = 4'b1011;
        tick();
        strobes_off();
        cnt_index = 1'b1;
        tick();
        tick();
        strobes_off();
        #1;
        check("wen_cnt_addr", int'(pattern_leds), 11);
        check("wen_cnt_count3", int'(index_lt_count), 1);

        // Saturation of both counters.
        for (int i = 0; i < DEPTH + 2; i++) begin
            cnt_count = 1'b1;
            tick();
        end
        strobes_off();
        clr_index = 1'b1;
        tick();
        strobes_off();
        for (int i = 0; i < MAXC - 1; i++) begin
            cnt_index = 1'b1;
            tick();
        end
        strobes_off();
        #1;
        check("idx62_lt", int'(index_lt_count), 1);
        for (int i = 0; i < 4; i++) begin
            cnt_index = 1'b1;
            tick();
        end
        strobes_off();
        #1;
        check("sat_lt", int'(index_lt_count), 0);
        w_en = 1'b1; pattern = 4'b0101;
        tick();
        strobes_off();
        #1;
        check("last_write", int'(pattern_leds), 5);
        w_en = 1'b1; cnt_count = 1'b1; pattern = 4'b0110;
        tick();
        strobes_off();
        #1;
        check("last_overwrite", int'(pattern_leds), 6);
        check("sat_lt_after", int'(index_lt_count), 0);

        // Reset mid-sequence keeps memory contents.
        clr_count = 1'b1; clr_index = 1'b1;
        tick();
        strobes_off();
        for (int i = 0; i < 7; i++) begin
            w_en = 1'b1; cnt_count = 1'b1; pattern = 4'(i + 1);
            tick();
        end
        strobes_off();
        for (int i = 0; i < 4; i++) begin
            cnt_index = 1'b1;
            tick();
        end
        strobes_off();
        #1;
        check("pre_rst_lt", int'(index_lt_count), 1);
        check("pre_rst_leds", int'(pattern_leds), 5);
        rst = 1'b1; cnt_index = 1'b1;
        tick();
        strobes_off();
        #1;
        check("post_rst_lt", int'(index_lt_count), 0);
        check("post_rst_mem0", int'(pattern_leds), 1);
        for (int i = 1; i < 7; i++) begin
            cnt_index = 1'b1;
            tick();
            strobes_off();
            #1;
            check("kept_mem", int'(pattern_leds), i + 1);
            check("kept_lt", int'(index_lt_count), 0);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simon_datapath.md
Name: simon_datapath

Overview:
- Datapath partner of the Simon control FSM. It stores the player-entered pattern sequence and tracks the sequence length (count) and the playback/repeat position (index).
- It produces the three status flags the FSM branches on: index_lt_count, input_eq_pattern and is_legal.
- It drives the 4 pattern LEDs: the memory word at index during playback, the live switch input otherwise.
- It acts purely on the FSM's strobes and never sequences itself.

Parameters:
- ADDR_W, 6, width of the count/index registers and the memory address.
- DEPTH, 2**ADDR_W, number of 4-bit pattern entries (default 64).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- level  input  1  difficulty switch: 0 = easy, 1 = hard. Sampled only when set_level=1.
- pattern  input  4  live player switch pattern.
- set_level  input  1  load the level register from level.
- w_en  input  1  write pattern into mem[count].
- cnt_count  input  1  increment count.
- clr_count  input  1  clear count to 0.
- cnt_index  input  1  increment index.
- clr_index  input  1  clear index to 0.
- read_Memory  input  1  LED source select: 1 = mem[index], 0 = pattern.
- index_lt_count  output  1  index < count (unsigned).
- input_eq_pattern  output  1  pattern == mem[index].
- is_legal  output  1  pattern is legal under the latched level.
- pattern_leds  output  4  LED drive.

Behaviour:

Registers:
- level_r (1 bit), count (ADDR_W bits), index (ADDR_W bits).
- mem: DEPTH x 4 bits.
- Everything updates on posedge clk only. There are no other clocked elements.

Reset:
- rst=1 forces count=0 and index=0 on the next edge, whatever the strobes are.
- On that edge, level_r loads level when set_level=1. The FSM asserts set_level during rst.
- mem is NOT reset. Its contents are undefined until written.
- Post-reset outputs:
  - index_lt_count=0.
  - is_legal follows pattern and level_r.
  - input_eq_pattern and pattern_leds depend on mem[0] and on pattern.

count:
- Priority: clr_count > cnt_count > hold.
- cnt_count at count=DEPTH-1 saturates. count holds DEPTH-1 and never wraps.

index:
- Priority: clr_index > cnt_index > hold.
- cnt_index at index=DEPTH-1 saturates.
- clr_index and cnt_index asserted together give index=0.

Memory write:
- When w_en=1, mem[count] <= pattern on the edge.
- The write address is the pre-edge count. A simultaneous cnt_count does not shift the address.
- A write at count=DEPTH-1 overwrites the last entry.

Memory read:
- Asynchronous, combinational from index, so the flags are valid in the same cycle the FSM uses them.
- A read of mem[index] in the cycle of a write to the same address returns the old data. The new data is visible the cycle after the edge.

Flags (all combinational, zero latency):
- index_lt_count = (index < count).
- input_eq_pattern = (pattern == mem[index]), full 4-bit compare.
- is_legal:
  - level_r=0 (easy): always 1.
  - level_r=1 (hard): 1 iff pattern is one-hot (exactly one bit set). 4'b0000 and multi-bit patterns are illegal.

pattern_leds:
- read_Memory ? mem[index] : pattern. Combinational.

Sequence semantics:
- Entries 0..count are valid.
- PLAYBACK walks index 0..count.
- REPEAT compares each entry. On a match at index==count, the FSM asserts cnt_count.

Test Plan:
1. Hard-mode legality. rst with level=1, then pattern 0001/0100/0000/0110/1111 -> is_legal = 1/1/0/0/0. Repeat with level=0 -> is_legal=1 for all five. Changing level after reset has no effect until the next set_level.
2. Write and playback. After reset, write 0010 (w_en) -> mem[0]=0010 and index_lt_count=0. Set read_Memory=1 -> pattern_leds=0010. cnt_count then cnt_index -> count=1, index=1, index_lt_count=0.
3. Compare. With mem[0]=0010 and index=0: pattern=0010 -> input_eq_pattern=1; pattern=0011 -> 0. With read_Memory=0, pattern_leds tracks pattern.
4. Priorities. clr_index & cnt_index at index=5 -> index=0. clr_count & cnt_count at count=3 -> count=0. w_en & cnt_count at count=2 -> entry lands in mem[2] and count=3.
5. Saturation. Issue DEPTH+2 cnt_count strobes -> count stops at 63. Same for index. index_lt_count=0 when index=count=63.
6. Reset mid-sequence. With count=7 and index=4, assert rst with cnt_index=1 -> count=0 and index=0 next cycle. mem[0..6] keeps its prior values (read back via index after new cnt_index strobes).
